// File: rtl/poisson_spike_gen.sv
// Bernoulli/Poisson spike generator: one random draw per timestep, refractory hold,
// one-entry valid/ready output register. Define SPIKE_COUNT_EN to add spike/drop counters.
module poisson_spike_gen #(
  parameter int unsigned N = 32,
  parameter int unsigned R = 8,
  parameter int unsigned T = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         step,
  input  logic [N-1:0] rate,
  input  logic [R-1:0] refrac,
  input  logic [N-1:0] rnd,
  output logic         pn_next,
  output logic         spike_valid,
  input  logic         spike_ready,
  output logic [T-1:0] spike_ts,
  output logic         busy,
  output logic         step_miss,
  output logic         overrun
`ifdef SPIKE_COUNT_EN
  ,
  output logic [31:0]  spike_count,
  output logic [15:0]  drop_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] CMP  = 2'd2;

`ifdef SPIKE_COUNT_EN
  localparam int unsigned SC_W = 32;
  localparam int unsigned DC_W = 16;
  logic [SC_W-1:0] spike_count_q, spike_count_d;
  logic [DC_W-1:0] drop_count_q, drop_count_d;
`endif

  logic [1:0]   state_q, state_d;
  logic [T-1:0] ts_cnt_q, ts_cnt_d;
  logic [T-1:0] cur_ts_q, cur_ts_d;
  logic [R-1:0] refrac_cnt_q, refrac_cnt_d;
  logic         pn_next_q, pn_next_d;
  logic         spike_valid_q, spike_valid_d;
  logic [T-1:0] spike_ts_q, spike_ts_d;
  logic         busy_q, busy_d;
  logic         step_miss_q, step_miss_d;
  logic         overrun_q, overrun_d;
  logic         accept;

  assign accept = spike_valid_q && spike_ready;

  // Next-state, draw decision and output-register update
  always_comb begin
    state_d       = state_q;
    ts_cnt_d      = ts_cnt_q;
    cur_ts_d      = cur_ts_q;
    refrac_cnt_d  = refrac_cnt_q;
    pn_next_d     = 1'b0;
    busy_d        = 1'b0;
    spike_valid_d = spike_valid_q;
    spike_ts_d    = spike_ts_q;
    step_miss_d   = step_miss_q;
    overrun_d     = overrun_q;
`ifdef SPIKE_COUNT_EN
    spike_count_d = spike_count_q;
    drop_count_d  = drop_count_q;
    if (accept && (spike_count_q != {SC_W{1'b1}}))
      spike_count_d = spike_count_q + SC_W'(1);
`endif

    if (step)
      ts_cnt_d = ts_cnt_q + T'(1);
    if (accept)
      spike_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (step && en) begin
          if (refrac_cnt_q != '0) begin
            refrac_cnt_d = refrac_cnt_q - R'(1);
          end else begin
            state_d   = DRAW;
            cur_ts_d  = ts_cnt_q;
            pn_next_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
      end
      DRAW: begin
        state_d = CMP;
        busy_d  = 1'b1;
        if (step)
          step_miss_d = 1'b1;
      end
      CMP: begin
        state_d = IDLE;
        if (step)
          step_miss_d = 1'b1;
        if (rnd < rate) begin
          refrac_cnt_d = refrac;
          // A slot being drained this cycle can be refilled immediately
          if (!spike_valid_q || accept) begin
            spike_valid_d = 1'b1;
            spike_ts_d    = cur_ts_q;
          end else begin
            overrun_d = 1'b1;
`ifdef SPIKE_COUNT_EN
            if (drop_count_q != {DC_W{1'b1}})
              drop_count_d = drop_count_q + DC_W'(1);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ts_cnt_q      <= '0;
      cur_ts_q      <= '0;
      refrac_cnt_q  <= '0;
      pn_next_q     <= 1'b0;
      spike_valid_q <= 1'b0;
      spike_ts_q    <= '0;
      busy_q        <= 1'b0;
      step_miss_q   <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef SPIKE_COUNT_EN
      spike_count_q <= '0;
      drop_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ts_cnt_q      <= ts_cnt_d;
      cur_ts_q      <= cur_ts_d;
      refrac_cnt_q  <= refrac_cnt_d;
      pn_next_q     <= pn_next_d;
      spike_valid_q <= spike_valid_d;
      spike_ts_q    <= spike_ts_d;
      busy_q        <= busy_d;
      step_miss_q   <= step_miss_d;
      overrun_q     <= overrun_d;
`ifdef SPIKE_COUNT_EN
      spike_count_q <= spike_count_d;
      drop_count_q  <= drop_count_d;
`endif
    end
  end

  assign pn_next     = pn_next_q;
  assign spike_valid = spike_valid_q;
  assign spike_ts    = spike_ts_q;
  assign busy        = busy_q;
  assign step_miss   = step_miss_q;
  assign overrun     = overrun_q;
`ifdef SPIKE_COUNT_EN
  assign spike_count = spike_count_q;
  assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_poisson_spike_gen.sv
// Scoreboard bench for poisson_spike_gen; a second T=4 instance exercises timestamp wrap.
module tb_poisson_spike_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        step;
  logic [31:0] rate;
  logic [7:0]  refrac;
  logic [31:0] rnd;
  logic        pn_next;
  logic        spike_valid;
  logic        spike_ready;
  logic [15:0] spike_ts;
  logic        busy;
  logic        step_miss;
  logic        overrun;

  logic        w_step;
  logic        w_pn_next;
  logic        w_spike_valid;
  logic [3:0]  w_spike_ts;
  logic        w_busy;
  logic        w_step_miss;
  logic        w_overrun;
`ifdef SPIKE_COUNT_EN
  logic [31:0] spike_count, w_spike_count;
  logic [15:0] drop_count, w_drop_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_ts;
  logic [3:0]  w_exp_ts;
  logic [15:0] exp_q[$];
  logic [3:0]  w_q[$];
  int          acc_cnt;

  always #5 clk = ~clk;

  poisson_spike_gen #(.N(32), .R(8), .T(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .step(step), .rate(rate), .refrac(refrac),
    .rnd(rnd), .pn_next(pn_next), .spike_valid(spike_valid),
    .spike_ready(spike_ready), .spike_ts(spike_ts), .busy(busy),
    .step_miss(step_miss), .overrun(overrun)
`ifdef SPIKE_COUNT_EN
    , .spike_count(spike_count), .drop_count(drop_count)
`endif
  );

  poisson_spike_gen #(.N(32), .R(8), .T(4)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .step(w_step), .rate(rate), .refrac(refrac),
    .rnd(rnd), .pn_next(w_pn_next), .spike_valid(w_spike_valid),
    .spike_ready(spike_ready), .spike_ts(w_spike_ts), .busy(w_busy),
    .step_miss(w_step_miss), .overrun(w_overrun)
`ifdef SPIKE_COUNT_EN
    , .spike_count(w_spike_count), .drop_count(w_drop_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_ts = '0;
    w_exp_ts = '0;
    exp_q.delete();
    w_q.delete();
    acc_cnt = 0;
  endtask

  // Full draw: step pulse, then through DRAW and CMP; returns where valid is visible
  task automatic do_draw(input logic spikes);
    if (spikes) exp_q.push_back(exp_ts);
    step = 1'b1;
    tick();
    step = 1'b0;
    exp_ts = exp_ts + 16'd1;
    tick();
    tick();
  endtask

  task automatic accept();
    spike_ready = 1'b1;
    tick();
    spike_ready = 1'b0;
    acc_cnt++;
  endtask

  task automatic check_pop(input string name);
    logic [15:0] e;
    e = exp_q.pop_front();
    checks++;
    if (spike_valid !== 1'b1) begin
      errors++; $display("FAIL %s valid: got %b want 1", name, spike_valid);
    end
    checks++;
    if (spike_ts !== e) begin
      errors++; $display("FAIL %s ts: got %0d want %0d", name, spike_ts, e);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pn_next, spike_valid, busy, step_miss, overrun} !== 5'b0) begin
      errors++; $display("FAIL reset flags: got %b want 00000",
                         {pn_next, spike_valid, busy, step_miss, overrun});
    end
    checks++;
    if (spike_ts !== 16'd0) begin
      errors++; $display("FAIL reset ts: got %0d want 0", spike_ts);
    end
  endtask

  task automatic test_spike_latency();
    en = 1'b1; rate = 32'h8000_0000; refrac = 8'd0; rnd = 32'h0000_0010;
    exp_q.push_back(exp_ts);
    step = 1'b1;
    tick();
    step = 1'b0;
    exp_ts = exp_ts + 16'd1;
    checks++;
    if (pn_next !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL lat draw: got pn=%b busy=%b want 1 1", pn_next, busy);
    end
    tick();
    checks++;
    if (pn_next !== 1'b0 || spike_valid !== 1'b0) begin
      errors++; $display("FAIL lat cmp: got pn=%b valid=%b want 0 0", pn_next, spike_valid);
    end
    tick();
    check_pop("latency");
    accept();
    checks++;
    if (spike_valid !== 1'b0) begin
      errors++; $display("FAIL lat clear: got %b want 0", spike_valid);
    end
  endtask

  task automatic test_rate_bounds();
    rate = 32'd0; rnd = 32'd0;
    do_draw(1'b0);
    checks++;
    if (spike_valid !== 1'b0) begin
      errors++; $display("FAIL rate0: got valid=%b want 0", spike_valid);
    end
    rate = 32'hFFFF_FFFF; rnd = 32'hFFFF_FFFE;
    do_draw(1'b1);
    check_pop("ratemax");
    accept();
    rnd = 32'hFFFF_FFFF;
    do_draw(1'b0);
    checks++;
    if (spike_valid !== 1'b0) begin
      errors++; $display("FAIL rndmax: got valid=%b want 0", spike_valid);
    end
  endtask

  task automatic test_refractory();
    rate = 32'h8000_0000; rnd = 32'h10; refrac = 8'd3;
    do_draw(1'b1);
    check_pop("refrac_first");
    accept();
    for (int i = 1; i <= 3; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      exp_ts = exp_ts + 16'd1;
      checks++;
      if (pn_next !== 1'b0) begin
        errors++; $display("FAIL refrac_hold%0d: got pn=%b want 0", i, pn_next);
      end
      tick();
    end
    refrac = 8'd0;
    exp_q.push_back(exp_ts);
    step = 1'b1;
    tick();
    step = 1'b0;
    exp_ts = exp_ts + 16'd1;
    checks++;
    if (pn_next !== 1'b1) begin
      errors++; $display("FAIL refrac_release: got pn=%b want 1", pn_next);
    end
    tick();
    tick();
    check_pop("refrac_release");
    accept();
    en = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    exp_ts = exp_ts + 16'd1;
    checks++;
    if (pn_next !== 1'b0) begin
      errors++; $display("FAIL en_off: got pn=%b want 0", pn_next);
    end
    en = 1'b1;
    tick();
    do_draw(1'b1);
    check_pop("en_off_ts");
    accept();
  endtask

  task automatic test_overrun();
    do_reset();
    spike_ready = 1'b0; rate = 32'h8000_0000; rnd = 32'h10; refrac = 8'd0;
    do_draw(1'b1);
    do_draw(1'b0);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %b want 1", overrun);
    end
    check_pop("overrun_hold");
`ifdef SPIKE_COUNT_EN
    checks++;
    if (drop_count !== 16'd1) begin
      errors++; $display("FAIL drop_count: got %0d want 1", drop_count);
    end
`endif
    accept();
    do_reset();
    do_draw(1'b1);
    void'(exp_q.pop_front());
    acc_cnt++;
    exp_q.push_back(exp_ts);
    step = 1'b1;
    tick();
    step = 1'b0;
    exp_ts = exp_ts + 16'd1;
    tick();
    spike_ready = 1'b1;
    tick();
    spike_ready = 1'b0;
    check_pop("back_to_back");
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_overrun: got %b want 0", overrun);
    end
    accept();
  endtask

  task automatic test_step_miss_wrap();
    do_reset();
    checks++;
    if (step_miss !== 1'b0) begin
      errors++; $display("FAIL miss_reset: got %b want 0", step_miss);
    end
    exp_q.push_back(exp_ts);
    step = 1'b1;
    tick();
    checks++;
    if (pn_next !== 1'b1) begin
      errors++; $display("FAIL miss_first: got pn=%b want 1", pn_next);
    end
    tick();
    step = 1'b0;
    exp_ts = exp_ts + 16'd2;
    checks++;
    if (pn_next !== 1'b0 || step_miss !== 1'b1) begin
      errors++; $display("FAIL miss_second: got pn=%b miss=%b want 0 1", pn_next, step_miss);
    end
    tick();
    check_pop("miss_ts0");
    accept();
    do_draw(1'b1);
    check_pop("miss_ts2");
    accept();
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w_step = 1'b1;
      tick();
      w_step = 1'b0;
      w_exp_ts = w_exp_ts + 4'd1;
    end
    en = 1'b1;
    w_q.push_back(w_exp_ts);
    w_step = 1'b1;
    tick();
    w_step = 1'b0;
    tick();
    tick();
    checks++;
    if (w_spike_valid !== 1'b1 || w_spike_ts !== w_q.pop_front()) begin
      errors++; $display("FAIL wrap: got valid=%b ts=%0d want 1 0", w_spike_valid, w_spike_ts);
    end
    spike_ready = 1'b1;
    tick();
    spike_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_draw(1'b1);
    check_pop("mid_pending");
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (pn_next !== 1'b1) begin
      errors++; $display("FAIL mid_draw: got pn=%b want 1", pn_next);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({pn_next, spike_valid, busy, step_miss, overrun} !== 5'b0) begin
      errors++; $display("FAIL mid_reset: got %b want 00000",
                         {pn_next, spike_valid, busy, step_miss, overrun});
    end
    do_reset();
  endtask

  task automatic test_spike_count();
    int budget;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(exp_ts);
      step = 1'b1;
      tick();
      step = 1'b0;
      exp_ts = exp_ts + 16'd1;
      budget = 6;
      while (spike_valid !== 1'b1 && budget > 0) begin
        tick();
        budget--;
      end
      if (budget == 0) begin
        checks++; errors++;
        $display("FAIL count_wait%0d: got valid=%b want 1 within budget", k, spike_valid);
        void'(exp_q.pop_front());
      end else begin
        check_pop("count_ev");
        accept();
      end
    end
`ifdef SPIKE_COUNT_EN
    checks++;
    if (spike_count !== 32'(acc_cnt)) begin
      errors++; $display("FAIL spike_count: got %0d want %0d", spike_count, acc_cnt);
    end
`endif
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL count_overrun: got %b want 0", overrun);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; step = 1'b0; w_step = 1'b0; spike_ready = 1'b0;
    rate = '0; refrac = '0; rnd = '0;
    exp_ts = '0; w_exp_ts = '0; acc_cnt = 0;
    test_reset();
    test_spike_latency();
    test_rate_bounds();
    test_refractory();
    test_overrun();
    test_step_miss_wrap();
    test_reset_mid();
    test_spike_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
